// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between the CPU core and the program loader (round-robin, loader-only in load mode).
// Latency: write ACK 2 cycles after the IDLE cycle that samples REQ, read ACK 2+RD_LAT cycles; all outputs registered.
// Backpressure: req/ack handshake; a requester holds REQ and its command stable until its one-cycle ACK pulse.
//
// Ports:
//   DCLK, RST                        clock, synchronous active-high reset
//   LOAD_MODE                        1 = only the loader may be granted
//   C_REQ/C_W/C_ADDR/C_WDATA         CPU request and command (held stable until C_ACK)
//   C_RDATA/C_ACK                    CPU read data (valid with C_ACK) and completion pulse
//   L_REQ/L_W/L_ADDR/L_WDATA         loader request and command
//   L_RDATA/L_ACK                    loader read data and completion pulse
//   M_W/MADDR/MDATAOUT/MDATAIN       memory port
//   GNT_C/GNT_L/BUSY                 ownership and busy status for the LED/debug mux
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                 DCLK,
    input  logic                 RST,
    input  logic                 LOAD_MODE,
    input  logic                 C_REQ,
    input  logic                 C_W,
    input  logic [ADDR_SIZE-1:0] C_ADDR,
    input  logic [WORD_SIZE-1:0] C_WDATA,
    output logic [WORD_SIZE-1:0] C_RDATA,
    output logic                 C_ACK,
    input  logic                 L_REQ,
    input  logic                 L_W,
    input  logic [ADDR_SIZE-1:0] L_ADDR,
    input  logic [WORD_SIZE-1:0] L_WDATA,
    output logic [WORD_SIZE-1:0] L_RDATA,
    output logic                 L_ACK,
    output logic                 M_W,
    output logic [ADDR_SIZE-1:0] MADDR,
    output logic [WORD_SIZE-1:0] MDATAOUT,
    input  logic [WORD_SIZE-1:0] MDATAIN,
    output logic                 GNT_C,
    output logic                 GNT_L,
    output logic                 BUSY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    state_t                 state_q, state_d;
    // last_l_q doubles as the current owner while a transaction is in flight,
    // since it is updated at the same edge as the grant.
    logic                   last_l_q, last_l_d;
    logic                   w_q, w_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   m_w_q, m_w_d;
    logic [ADDR_SIZE-1:0]   maddr_q, maddr_d;
    logic [WORD_SIZE-1:0]   mdataout_q, mdataout_d;
    logic                   c_ack_q, c_ack_d;
    logic                   l_ack_q, l_ack_d;
    logic [WORD_SIZE-1:0]   c_rdata_q, c_rdata_d;
    logic [WORD_SIZE-1:0]   l_rdata_q, l_rdata_d;
    logic                   gnt_c_q, gnt_c_d;
    logic                   gnt_l_q, gnt_l_d;
    logic                   busy_q, busy_d;

    logic                   c_elig;
    logic                   l_elig;
    logic                   pick_l;

    always_ff @(posedge DCLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            last_l_q   <= 1'b1;
            w_q        <= 1'b0;
            cnt_q      <= '0;
            m_w_q      <= 1'b0;
            maddr_q    <= '0;
            mdataout_q <= '0;
            c_ack_q    <= 1'b0;
            l_ack_q    <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
            gnt_c_q    <= 1'b0;
            gnt_l_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_l_q   <= last_l_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            m_w_q      <= m_w_d;
            maddr_q    <= maddr_d;
            mdataout_q <= mdataout_d;
            c_ack_q    <= c_ack_d;
            l_ack_q    <= l_ack_d;
            c_rdata_q  <= c_rdata_d;
            l_rdata_q  <= l_rdata_d;
            gnt_c_q    <= gnt_c_d;
            gnt_l_q    <= gnt_l_d;
            busy_q     <= busy_d;
        end
    end

    // Load mode removes the CPU from the eligible set; on a tie the side that
    // was not granted last wins.
    assign c_elig = C_REQ & ~LOAD_MODE;
    assign l_elig = L_REQ;
    assign pick_l = l_elig & (~c_elig | ~last_l_q);

    always_comb begin
        state_d    = state_q;
        last_l_d   = last_l_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        m_w_d      = 1'b0;
        maddr_d    = maddr_q;
        mdataout_d = mdataout_q;
        c_ack_d    = 1'b0;
        l_ack_d    = 1'b0;
        c_rdata_d  = c_rdata_q;
        l_rdata_d  = l_rdata_q;
        gnt_c_d    = gnt_c_q;
        gnt_l_d    = gnt_l_q;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (c_elig | l_elig) begin
                    state_d    = S_ACCESS;
                    last_l_d   = pick_l;
                    w_d        = pick_l ? L_W : C_W;
                    // Outputs are registered, so the command is loaded straight
                    // into the memory-port registers for the ACCESS cycle.
                    maddr_d    = pick_l ? L_ADDR : C_ADDR;
                    mdataout_d = pick_l ? L_WDATA : C_WDATA;
                    m_w_d      = pick_l ? L_W : C_W;
                    gnt_c_d    = ~pick_l;
                    gnt_l_d    = pick_l;
                    busy_d     = 1'b1;
                end
            end
            S_ACCESS: begin
                if (w_q) begin
                    state_d = S_RESP;
                    c_ack_d = ~last_l_q;
                    l_ack_d = last_l_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = RD_LAT_C;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    c_ack_d = ~last_l_q;
                    l_ack_d = last_l_q;
                    if (last_l_q) begin
                        l_rdata_d = MDATAIN;
                    end else begin
                        c_rdata_d = MDATAIN;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_c_d = 1'b0;
                gnt_l_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign M_W      = m_w_q;
    assign MADDR    = maddr_q;
    assign MDATAOUT = mdataout_q;
    assign C_ACK    = c_ack_q;
    assign L_ACK    = l_ack_q;
    assign C_RDATA  = c_rdata_q;
    assign L_RDATA  = l_rdata_q;
    assign GNT_C    = gnt_c_q;
    assign GNT_L    = gnt_l_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model with per-cycle compare,
// plus directed scenarios with hand-computed expectations (main DUT RD_LAT=1, second DUT RD_LAT=3).
// Inputs are driven on the falling edge; outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    localparam int RD1 = 1;

    logic        DCLK;
    logic        RST;
    logic        LOAD_MODE;
    logic        C_REQ, C_W, L_REQ, L_W;
    logic [15:0] C_ADDR, C_WDATA, L_ADDR, L_WDATA;
    logic [15:0] C_RDATA, L_RDATA, MADDR, MDATAOUT, mdi;
    logic        C_ACK, L_ACK, M_W, GNT_C, GNT_L, BUSY;

    // second instance, RD_LAT=3, CPU side only
    logic        c3_req, c3_w, lm3, l3_req, l3_w;
    logic [15:0] c3_addr, c3_wdata, l3_addr, l3_wdata;
    logic [15:0] c3_rdata, l3_rdata, maddr3, mdo3, mdi3;
    logic        c3_ack, l3_ack, m3_w, gnt_c3, gnt_l3, busy3;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16), .RD_LAT(RD1)) dut (
        .DCLK(DCLK), .RST(RST), .LOAD_MODE(LOAD_MODE),
        .C_REQ(C_REQ), .C_W(C_W), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
        .C_RDATA(C_RDATA), .C_ACK(C_ACK),
        .L_REQ(L_REQ), .L_W(L_W), .L_ADDR(L_ADDR), .L_WDATA(L_WDATA),
        .L_RDATA(L_RDATA), .L_ACK(L_ACK),
        .M_W(M_W), .MADDR(MADDR), .MDATAOUT(MDATAOUT), .MDATAIN(mdi),
        .GNT_C(GNT_C), .GNT_L(GNT_L), .BUSY(BUSY)
    );

    mem_port_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16), .RD_LAT(3)) dut3 (
        .DCLK(DCLK), .RST(RST), .LOAD_MODE(lm3),
        .C_REQ(c3_req), .C_W(c3_w), .C_ADDR(c3_addr), .C_WDATA(c3_wdata),
        .C_RDATA(c3_rdata), .C_ACK(c3_ack),
        .L_REQ(l3_req), .L_W(l3_w), .L_ADDR(l3_addr), .L_WDATA(l3_wdata),
        .L_RDATA(l3_rdata), .L_ACK(l3_ack),
        .M_W(m3_w), .MADDR(maddr3), .MDATAOUT(mdo3), .MDATAIN(mdi3),
        .GNT_C(gnt_c3), .GNT_L(gnt_l3), .BUSY(busy3)
    );

    initial begin
        DCLK = 1'b0;
        forever #5 DCLK = ~DCLK;
    end

    // ---------------- memory environments ----------------
    logic [15:0] ram [256];
    logic        ram_init = 1'b0;
    always @(posedge DCLK) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
            ram_init = 1'b1;
        end
        mdi <= ram[MADDR[7:0]];
        if (M_W === 1'b1) ram[MADDR[7:0]] = MDATAOUT;
    end

    logic [15:0] ram3 [256];
    logic [15:0] p3 [3];
    logic        ram3_init = 1'b0;
    always @(posedge DCLK) begin
        if (!ram3_init) begin
            for (int i = 0; i < 256; i++) ram3[i] = 16'h0000;
            ram3_init = 1'b1;
        end
        p3[0] <= ram3[maddr3[7:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (m3_w === 1'b1) ram3[maddr3[7:0]] = mdo3;
    end
    assign mdi3 = p3[2];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        gc;
        logic        gl;
        logic        busy;
        logic        mw;
        logic        cack;
        logic        lack;
        logic [15:0] maddr;
        logic [15:0] mdo;
        logic [15:0] crd;
        logic [15:0] lrd;
    } exp_t;

    exp_t        cur;
    exp_t        m_r;
    exp_t        sched [$];
    logic        started = 1'b0;
    logic        m_last_l;
    logic        m_ce, m_le, m_pl, m_w;
    logic [15:0] m_a, m_d, m_rv;
    int          m_len;
    logic [15:0] ref_mem [256];
    logic        ref_init = 1'b0;

    // Each granted transaction becomes a fixed schedule of per-cycle
    // expectations: len busy cycles (ACK on the last) plus the IDLE cycle
    // that follows; arbitration happens only at the end of an IDLE cycle.
    always @(posedge DCLK) begin
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 + 16'(i);
            ref_init = 1'b1;
        end
        if (RST) begin
            sched.delete();
            m_last_l = 1'b1;
            cur = '0;
            started = 1'b1;
        end else begin
            if (sched.size() == 0) begin
                m_ce = C_REQ && !LOAD_MODE;
                m_le = L_REQ;
                if (m_ce || m_le) begin
                    m_pl = m_le && (!m_ce || !m_last_l);
                    m_last_l = m_pl;
                    m_w = m_pl ? L_W : C_W;
                    m_a = m_pl ? L_ADDR : C_ADDR;
                    m_d = m_pl ? L_WDATA : C_WDATA;
                    m_len = m_w ? 2 : 2 + RD1;
                    m_rv = ref_mem[m_a[7:0]];
                    if (m_w) ref_mem[m_a[7:0]] = m_d;
                    for (int k = 1; k <= m_len + 1; k++) begin
                        m_r = '0;
                        m_r.maddr = m_a;
                        m_r.mdo = m_d;
                        m_r.crd = cur.crd;
                        m_r.lrd = cur.lrd;
                        if (k <= m_len) begin
                            m_r.gc = !m_pl;
                            m_r.gl = m_pl;
                            m_r.busy = 1'b1;
                        end
                        m_r.mw = (k == 1) && m_w;
                        if (k == m_len) begin
                            m_r.cack = !m_pl;
                            m_r.lack = m_pl;
                        end
                        if (k >= m_len && !m_w) begin
                            if (m_pl) m_r.lrd = m_rv;
                            else      m_r.crd = m_rv;
                        end
                        sched.push_back(m_r);
                    end
                end
            end
            if (sched.size() != 0) begin
                cur = sched.pop_front();
            end else begin
                cur.gc = 1'b0;
                cur.gl = 1'b0;
                cur.busy = 1'b0;
                cur.mw = 1'b0;
                cur.cack = 1'b0;
                cur.lack = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge DCLK) begin
        if (started) begin
            chk("cyc_gnt_c", 32'(GNT_C), 32'(cur.gc));
            chk("cyc_gnt_l", 32'(GNT_L), 32'(cur.gl));
            chk("cyc_busy",  32'(BUSY),  32'(cur.busy));
            chk("cyc_m_w",   32'(M_W),   32'(cur.mw));
            chk("cyc_c_ack", 32'(C_ACK), 32'(cur.cack));
            chk("cyc_l_ack", 32'(L_ACK), 32'(cur.lack));
            chk("cyc_maddr", 32'(MADDR), 32'(cur.maddr));
            if (cur.mw)   chk("cyc_mdataout", 32'(MDATAOUT), 32'(cur.mdo));
            if (cur.cack) chk("cyc_c_rdata",  32'(C_RDATA),  32'(cur.crd));
            if (cur.lack) chk("cyc_l_rdata",  32'(L_RDATA),  32'(cur.lrd));
        end
    end

    // One request on the main DUT; call from a falling edge inside an IDLE cycle.
    // Returns ACK latency (0 = timed out), read data, and M_W/MADDR of the first cycle.
    task automatic req_op(input bit is_l, input bit w, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd,
                          output logic mw1, output logic [15:0] ma1);
        lat = 0;
        rd = '0;
        mw1 = 1'b0;
        ma1 = '0;
        if (is_l) begin
            L_REQ = 1'b1; L_W = w; L_ADDR = a; L_WDATA = d;
        end else begin
            C_REQ = 1'b1; C_W = w; C_ADDR = a; C_WDATA = d;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge DCLK);
            if (n == 1) begin
                mw1 = M_W;
                ma1 = MADDR;
            end
            if ((is_l ? L_ACK : C_ACK) === 1'b1) begin
                lat = n;
                rd = is_l ? L_RDATA : C_RDATA;
                break;
            end
        end
        if (is_l) L_REQ = 1'b0;
        else      C_REQ = 1'b0;
        if (lat == 0) chk("req_timeout", 32'd0, 32'd1);
        @(negedge DCLK);
    endtask

    int          lat;
    logic [15:0] rd, ma1;
    logic        mw1;
    int          nack, lcnt, ccnt, seen;
    logic        order [4];

    initial begin
        RST = 1'b1; LOAD_MODE = 1'b0;
        C_REQ = 1'b0; C_W = 1'b0; C_ADDR = '0; C_WDATA = '0;
        L_REQ = 1'b0; L_W = 1'b0; L_ADDR = '0; L_WDATA = '0;
        c3_req = 1'b0; c3_w = 1'b0; c3_addr = '0; c3_wdata = '0;
        lm3 = 1'b0; l3_req = 1'b0; l3_w = 1'b0; l3_addr = '0; l3_wdata = '0;
        repeat (2) @(negedge DCLK);
        chk("rst_busy",  32'(BUSY),  32'd0);
        chk("rst_gnt_c", 32'(GNT_C), 32'd0);
        chk("rst_c_ack", 32'(C_ACK), 32'd0);
        chk("rst_maddr", 32'(MADDR), 32'd0);
        RST = 1'b0;

        // 1: CPU write 0x0010 = 0xBEEF
        req_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, rd, mw1, ma1);
        chk("t1_m_w_access", 32'(mw1), 32'd1);
        chk("t1_maddr",      32'(ma1), 32'h0010);
        chk("t1_latency",    32'(lat), 32'd2);

        // 2: CPU read back, RD_LAT=1
        req_op(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, mw1, ma1);
        chk("t2_latency", 32'(lat), 32'd3);
        chk("t2_rdata",   32'(rd),  32'hBEEF);
        chk("t2_m_w",     32'(mw1), 32'd0);

        // 3: both requesting continuously from reset -> C, L, C, L
        RST = 1'b1;
        C_REQ = 1'b1; C_W = 1'b1; C_ADDR = 16'h0050; C_WDATA = 16'h5555;
        L_REQ = 1'b1; L_W = 1'b1; L_ADDR = 16'h0060; L_WDATA = 16'h6666;
        @(negedge DCLK);
        RST = 1'b0;
        nack = 0;
        for (int n = 0; n < 40 && nack < 4; n++) begin
            @(negedge DCLK);
            if (C_ACK === 1'b1 || L_ACK === 1'b1) begin
                order[nack] = L_ACK;
                nack++;
            end
        end
        C_REQ = 1'b0; L_REQ = 1'b0;
        chk("t3_ack_count", 32'(nack), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_rr_order", 32'(order[i]), 32'(i % 2));
        @(negedge DCLK);

        // 4: load mode -> only loader writes; then CPU granted next IDLE
        LOAD_MODE = 1'b1;
        C_REQ = 1'b1; C_W = 1'b0; C_ADDR = 16'h0010;
        L_REQ = 1'b1; L_W = 1'b1; L_ADDR = 16'h0020; L_WDATA = 16'h1000;
        lcnt = 0; ccnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge DCLK);
            if (C_ACK === 1'b1) ccnt++;
            if (L_ACK === 1'b1) begin
                lcnt++;
                if (lcnt == 4) begin
                    LOAD_MODE = 1'b0;
                    L_REQ = 1'b0;
                    break;
                end
                L_ADDR = 16'h0020 + 16'(lcnt);
                L_WDATA = 16'h1000 + 16'(lcnt);
            end
        end
        chk("t4_loader_acks", 32'(lcnt), 32'd4);
        chk("t4_cpu_acks",    32'(ccnt), 32'd0);
        @(negedge DCLK);
        @(negedge DCLK);
        chk("t4_cpu_granted", 32'(GNT_C), 32'd1);
        chk("t4_loader_gnt",  32'(GNT_L), 32'd0);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (C_ACK === 1'b1) begin
                seen = 1;
                chk("t4_cpu_rdata", 32'(C_RDATA), 32'hBEEF);
                break;
            end
            @(negedge DCLK);
        end
        chk("t4_cpu_ack_seen", 32'(seen), 32'd1);
        C_REQ = 1'b0;
        @(negedge DCLK);
        req_op(1'b0, 1'b0, 16'h0022, 16'h0000, lat, rd, mw1, ma1);
        chk("t4_readback", 32'(rd), 32'h1002);

        // 5: reset during WAIT of a loader read
        L_REQ = 1'b1; L_W = 1'b0; L_ADDR = 16'h0030;
        @(negedge DCLK);
        @(negedge DCLK);
        chk("t5_in_wait_gnt_l", 32'(GNT_L), 32'd1);
        RST = 1'b1; L_REQ = 1'b0;
        @(negedge DCLK);
        chk("t5_busy",  32'(BUSY),  32'd0);
        chk("t5_gnt_l", 32'(GNT_L), 32'd0);
        RST = 1'b0;
        lcnt = 0;
        for (int n = 0; n < 6; n++) begin
            if (L_ACK === 1'b1) lcnt++;
            @(negedge DCLK);
        end
        chk("t5_no_l_ack", 32'(lcnt), 32'd0);
        req_op(1'b1, 1'b0, 16'h0030, 16'h0000, lat, rd, mw1, ma1);
        chk("t5_reissue_lat",   32'(lat), 32'd3);
        chk("t5_reissue_rdata", 32'(rd),  32'hA030);

        // 6: RD_LAT=3 instance
        c3_req = 1'b1; c3_w = 1'b1; c3_addr = 16'h0040; c3_wdata = 16'h1234;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge DCLK);
            if (c3_ack === 1'b1) begin
                lat = n;
                break;
            end
        end
        c3_req = 1'b0;
        chk("t6_write_lat", 32'(lat), 32'd2);
        @(negedge DCLK);
        c3_req = 1'b1; c3_w = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge DCLK);
            if (n <= 4) chk("t6_maddr_stable", 32'(maddr3), 32'h0040);
            chk("t6_m_w_low", 32'(m3_w), 32'd0);
            if (c3_ack === 1'b1) begin
                lat = n;
                chk("t6_rdata", 32'(c3_rdata), 32'h1234);
                break;
            end
        end
        c3_req = 1'b0;
        chk("t6_read_lat", 32'(lat), 32'd5);
        repeat (3) @(negedge DCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
